alu_req_ctrl: RTL and testbench
===============================

# alu_req_ctrl

Request-side controller for the shared integer `alu`. It accepts RV32I OP/OP-IMM style operation requests over a valid/ready handshake and buffers them in a small FIFO. It decodes `funct3`/`funct7[5]` into the ALU `s`/`ext` controls, drives one `alu` instance, and returns registered results over a second valid/ready handshake. It sits between the decode/issue stage and the datapath, replacing direct combinational wiring of the ALU.

## Interface
- `DATA_W`, 32, operand/result width
- `SHAMT_W`, 5, shift-amount width; the ALU uses `b[SHAMT_W-1:0]`
- `OP_W`, 3, ALU op-select width
- `FIFO_DEPTH`, 2, request FIFO entries; must be a power of 2 and ≥2
- `TAG_W`, 4, request tag width

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: request valid
- `in_ready` out 1: FIFO can accept
- `in_opimm` in 1: 1 = OP-IMM (b is the immediate), 0 = OP
- `in_funct3` in OP_W: RISC-V funct3
- `in_funct7_5` in 1: funct7 bit 5 / imm[10]
- `in_a` in DATA_W: rs1 value
- `in_b` in DATA_W: rs2 value or sign-extended immediate
- `in_tag` in TAG_W: opaque, returned with the result
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts
- `out_y` out DATA_W: ALU result
- `out_tag` out TAG_W: tag of the result
- `out_err` out 1: illegal encoding flag (see Configuration)
- `busy` out 1: `(fifo count != 0) | out_valid`

## Operation
- Push occurs when `in_valid & in_ready`. `in_ready = (count < FIFO_DEPTH)`, a function of registered state only and never of `out_ready`.
- FIFO entry fields: `opimm`, `funct3`, `funct7_5`, `a`, `b`, `tag`. Write/read pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits.
- Decode is applied to the FIFO head:
  - `s = funct3`
  - `ext = funct7_5 & ((funct3==3'b000 & !opimm) | funct3==3'b101)`
  - So SUB applies only to OP, SRA/SRAI to both, and ADDI ignores bit 5.
- Pop fires when `count != 0 & (!out_valid | out_ready)`. On pop, the result register loads `alu.y`, the head tag, and the error flag, and `out_valid` is set.
- When `out_valid & out_ready` occurs and there is no pop in the same cycle, `out_valid` clears. `out_y`/`out_tag` keep their last value.
- Simultaneous push and pop: count is unchanged and both pointers advance. Push at full cannot occur because `in_ready` is 0.
- Output holds stable while `out_valid & !out_ready`.
- Arithmetic follows the `alu` block: ADD/SUB wrap modulo 2^DATA_W, and shifts use the low SHAMT_W bits of b.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - count, pointers = 0
  - `out_valid` = 0, `out_y` = 0, `out_tag` = 0, `out_err` = 0
  - `in_ready` = 1, `busy` = 0
- Latency: a request accepted at edge k gives `out_valid` = 1 after edge k+1 (2 cycles from the in_valid presentation cycle to the result), provided the output stage is free.
- Throughput is 1 result/cycle with `out_ready` held high.
- Maximum in-flight is FIFO_DEPTH + 1, counting the output register.
- Reset asserted mid-operation discards all buffered requests and the pending result immediately. No partial output appears.

## Configuration
- `ALU_REQ_ILLEGAL_CHK_EN` defined: `out_err` = 1 with the result when the popped entry has `funct7_5=1` and `funct3` is not in {101} ∪ ({000} if !opimm). The result is still computed per the decode above.
- Not defined: `out_err` is tied to 0, and no check logic or FIFO storage is added for it.

## Structure
- Shared package `alu_pkg`:
  - Op constants: `ALU_ADD`=000, `ALU_SLL`=001, `ALU_SLT`=010, `ALU_SLTU`=011, `ALU_XOR`=100, `ALU_SR`=101, `ALU_OR`=110, `ALU_AND`=111.
  - The default widths.
- One sub-module: the existing `alu` (params `DATA_W`, `SHAMT_W`, `OP`), instantiated once and fed by the FIFO head. The FIFO stays inline.

## Test plan
- Reset, then one OP request: AND, a=6, b=3, tag=1 → `out_valid` 2 cycles later, `out_y`=2, `out_tag`=1.
- OP, funct3=000, funct7_5=1, a=5, b=7 → `out_y`=0xFFFFFFFE. Same with `in_opimm`=1 (ADDI) → 12.
- OP-IMM, funct3=101, funct7_5=1, a=0x80000000, b=4 → 0xF8000000. With funct7_5=0 → 0x08000000.
- Backpressure: `out_ready`=0, push 4 requests → 3 accepted, `in_ready`=0 on the 4th. Release `out_ready` → results return in order with tags 0,1,2, then the 4th is accepted.
- Reset pulse while 2 requests are buffered → `out_valid`=0, `busy`=0, and no results after release.
- With `ALU_REQ_ILLEGAL_CHK_EN`: OP, funct3=111, funct7_5=1, a=6, b=3 → `out_y`=2, `out_err`=1. Without the macro, `out_err`=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU package: op-select encodings, default widths and funct7[5] decode helpers.
package alu_pkg;

  localparam int unsigned ALU_DATA_W     = 32;
  localparam int unsigned ALU_SHAMT_W    = 5;
  localparam int unsigned ALU_OP_W       = 3;
  localparam int unsigned ALU_FIFO_DEPTH = 2;
  localparam int unsigned ALU_TAG_W      = 4;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  // funct7[5] is meaningful only for SUB (OP form) and SRA/SRAI.
  function automatic logic alu_ext_ok(input logic opimm, input logic [2:0] funct3);
    return (funct3 == ALU_SR) | ((funct3 == ALU_ADD) & ~opimm);
  endfunction

endpackage

// File: rtl/alu_req_ctrl_if.sv
// Request/result handshake bundle for alu_req_ctrl; master is the issuer, slave the controller.
interface alu_req_ctrl_if
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned OP_W   = ALU_OP_W,
  parameter int unsigned TAG_W  = ALU_TAG_W
);

  logic              in_valid;
  logic              in_ready;
  logic              in_opimm;
  logic [OP_W-1:0]   in_funct3;
  logic              in_funct7_5;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_y;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport master (
    output in_valid, in_opimm, in_funct3, in_funct7_5, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_opimm, in_funct3, in_funct7_5, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag, out_err
  );

endinterface

// File: rtl/alu.sv
// Combinational RV32I integer ALU: s selects the op, ext turns ADD into SUB and SRL into SRA.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = ALU_DATA_W,
  parameter int unsigned SHAMT_W = ALU_SHAMT_W,
  parameter int unsigned OP      = ALU_OP_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP-1:0]     s,
  input  logic              ext,
  output logic [DATA_W-1:0] y
);

  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  sra;
  logic [DATA_W-1:0]  srl;

  assign shamt = b[SHAMT_W-1:0];
  // Kept separate so the arithmetic shift is not demoted to unsigned by the mux.
  assign sra   = $signed(a) >>> shamt;
  assign srl   = a >> shamt;

  always_comb begin
    y = '0;
    unique case (alu_op_e'(s))
      ALU_ADD:  y = ext ? (a - b) : (a + b);
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SR:   y = ext ? sra : srl;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_ctrl.sv
// Buffered request controller for the shared alu: request FIFO, head decode, registered result.
// Optional illegal-encoding flag on out_err is enabled by defining ALU_REQ_ILLEGAL_CHK_EN.
module alu_req_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W     = ALU_DATA_W,
  parameter int unsigned SHAMT_W    = ALU_SHAMT_W,
  parameter int unsigned OP_W       = ALU_OP_W,
  parameter int unsigned FIFO_DEPTH = ALU_FIFO_DEPTH,
  parameter int unsigned TAG_W      = ALU_TAG_W
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_req_ctrl_if.slave  bus,
  output logic           busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              opimm;
    logic [OP_W-1:0]   funct3;
    logic              funct7_5;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } req_t;

  req_t              fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_y_q;
  logic [TAG_W-1:0]  out_tag_q;

  req_t              head;
  logic              push, pop;
  logic              head_ext_ok;
  logic [DATA_W-1:0] alu_y;

  assign head         = fifo_q[rd_ptr_q];
  assign bus.in_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = (count_q != '0) & (~out_valid_q | bus.out_ready);
  assign head_ext_ok  = alu_ext_ok(head.opimm, 3'(head.funct3));

  alu #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W),
    .OP      (OP_W)
  ) u_alu (
    .a   (head.a),
    .b   (head.b),
    .s   (head.funct3),
    .ext (head.funct7_5 & head_ext_ok),
    .y   (alu_y)
  );

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{opimm:    bus.in_opimm,
                            funct3:   bus.in_funct3,
                            funct7_5: bus.in_funct7_5,
                            a:        bus.in_a,
                            b:        bus.in_b,
                            tag:      bus.in_tag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        out_valid_q <= 1'b1;
        out_y_q     <= alu_y;
        out_tag_q   <= head.tag;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_REQ_ILLEGAL_CHK_EN
  logic out_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err_q <= 1'b0;
    end else if (pop) begin
      out_err_q <= head.funct7_5 & ~head_ext_ok;
    end
  end

  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_tag   = out_tag_q;
  assign busy          = (count_q != '0) | out_valid_q;

endmodule

// File: tb/tb_alu_req_ctrl.sv
// Directed self-checking bench for alu_req_ctrl (expected err flag follows ALU_REQ_ILLEGAL_CHK_EN).
module tb_alu_req_ctrl;
  import alu_pkg::*;

`ifdef ALU_REQ_ILLEGAL_CHK_EN
  localparam logic ChkEn = 1'b1;
`else
  localparam logic ChkEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  alu_req_ctrl_if bus ();

  alu_req_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic opimm, input logic [2:0] f3, input logic f75,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    bus.in_valid    = 1'b1;
    bus.in_opimm    = opimm;
    bus.in_funct3   = f3;
    bus.in_funct7_5 = f75;
    bus.in_a        = a;
    bus.in_b        = b;
    bus.in_tag      = tag;
  endtask

  // One request with out_ready high: result must appear exactly one edge after acceptance.
  task automatic single(input string tag, input logic opimm, input logic [2:0] f3,
                        input logic f75, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] rtag, input logic [31:0] exp_y, input logic exp_err);
    drive(opimm, f3, f75, a, b, rtag);
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_notyet"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_y"}, bus.out_y, exp_y);
    chk({tag, "_tag"}, 32'(bus.out_tag), 32'(rtag));
    chk({tag, "_err"}, 32'(bus.out_err), 32'(exp_err));
    step();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.in_opimm = 1'b0; bus.in_funct3 = '0; bus.in_funct7_5 = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_y", bus.out_y, 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    single("and",   1'b0, 3'b111, 1'b0, 32'd6, 32'd3, 4'd1, 32'd2, 1'b0);
    single("sub",   1'b0, 3'b000, 1'b1, 32'd5, 32'd7, 4'd2, 32'hFFFF_FFFE, 1'b0);
    single("addi",  1'b1, 3'b000, 1'b1, 32'd5, 32'd7, 4'd3, 32'd12, ChkEn);
    single("srai",  1'b1, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 4'd4, 32'hF800_0000, 1'b0);
    single("srli",  1'b1, 3'b101, 1'b0, 32'h8000_0000, 32'd4, 4'd5, 32'h0800_0000, 1'b0);
    single("slt",   1'b0, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd6, 32'd1, 1'b0);
    single("sltu",  1'b0, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd7, 32'd0, 1'b0);
    single("sll",   1'b0, 3'b001, 1'b0, 32'd3, 32'h21, 4'd8, 32'd6, 1'b0);
    single("andil", 1'b0, 3'b111, 1'b1, 32'd6, 32'd3, 4'd9, 32'd2, ChkEn);

    // Back-to-back throughput.
    drive(1'b0, 3'b000, 1'b0, 32'd100, 32'd1, 4'd5);
    step();
    drive(1'b0, 3'b100, 1'b0, 32'hF0, 32'hFF, 4'd6);
    step();
    chk("tp0_valid", 32'(bus.out_valid), 32'd1);
    chk("tp0_y", bus.out_y, 32'd101);
    chk("tp0_tag", 32'(bus.out_tag), 32'd5);
    drive(1'b0, 3'b110, 1'b0, 32'hF0, 32'h0F, 4'd7);
    step();
    chk("tp1_y", bus.out_y, 32'h0F);
    chk("tp1_tag", 32'(bus.out_tag), 32'd6);
    chk("tp1_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    step();
    chk("tp2_y", bus.out_y, 32'hFF);
    chk("tp2_tag", 32'(bus.out_tag), 32'd7);
    step();
    chk("tp_drain", 32'(bus.out_valid), 32'd0);

    // Backpressure: FIFO plus output register hold three requests.
    bus.out_ready = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 32'd0, 32'd1, 4'd0);
    step();
    drive(1'b0, 3'b000, 1'b0, 32'd10, 32'd1, 4'd1);
    step();
    drive(1'b0, 3'b000, 1'b0, 32'd20, 32'd1, 4'd2);
    step();
    chk("bp_full", 32'(bus.in_ready), 32'd0);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_head_tag", 32'(bus.out_tag), 32'd0);
    drive(1'b0, 3'b000, 1'b0, 32'd30, 32'd1, 4'd3);
    step();
    chk("bp_still_full", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_y", bus.out_y, 32'd1);
    chk("bp_hold_tag", 32'(bus.out_tag), 32'd0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_r1_tag", 32'(bus.out_tag), 32'd1);
    chk("bp_r1_y", bus.out_y, 32'd11);
    chk("bp_space", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_r2_tag", 32'(bus.out_tag), 32'd2);
    chk("bp_r2_y", bus.out_y, 32'd21);
    step();
    chk("bp_r3_tag", 32'(bus.out_tag), 32'd3);
    chk("bp_r3_y", bus.out_y, 32'd31);
    chk("bp_r3_valid", 32'(bus.out_valid), 32'd1);
    step();
    chk("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Reset while work is buffered discards everything.
    bus.out_ready = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 32'd1, 32'd1, 4'd10);
    step();
    drive(1'b0, 3'b000, 1'b0, 32'd2, 32'd1, 4'd11);
    step();
    drive(1'b0, 3'b000, 1'b0, 32'd3, 32'd1, 4'd12);
    step();
    bus.in_valid = 1'b0;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_quiet", 32'(bus.out_valid), 32'd0);
    end

    single("recover", 1'b0, 3'b110, 1'b0, 32'h5, 32'hA, 4'd13, 32'hF, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
